// File: rtl/polyphase_resampler.sv
// Polyphase fractional-rate resampler: one coefficient row per output, chosen by
// an integer phase accumulator, applied to a TAPS-deep delay line with one MAC per cycle.
module polyphase_resampler #(
    parameter int FILTERS = 40,
    parameter int TAPS    = 6,
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 18,
    parameter int STEP_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [COEF_W-1:0] coef [FILTERS][TAPS],
    input  logic [STEP_W-1:0]        step,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [1:0]               o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and both ready/valid here are registered.
    localparam int PH_W   = $clog2(FILTERS);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + TAP_W;

    localparam logic [STEP_W:0]        FILT_L  = (STEP_W + 1)'(FILTERS);
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(2 ** (COEF_W - 2));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_n;
    logic signed [DATA_W-1:0]  r_d [TAPS];
    logic [STEP_W:0]           r_acc;
    logic [CNT_W-1:0]          r_fill_cnt;
    logic [TAP_W-1:0]          r_tap;
    logic signed [ACC_W-1:0]   r_sum;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic signed [DATA_W-1:0]  r_out_data;

    logic                      w_in_fire;
    logic                      w_out_fire;
    logic                      w_last_tap;
    logic                      w_fill_done;
    logic                      w_load_done;
    logic [STEP_W:0]           w_acc_step;
    logic [STEP_W:0]           w_acc_sub;
    logic [PH_W-1:0]           w_phase;
    logic [TAP_W-1:0]          w_didx;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [DATA_W-1:0]  w_sample;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_sum_base;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_round;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [DATA_W-1:0]  w_y;

    assign w_in_fire   = r_in_ready && in_valid;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_last_tap  = (r_tap == TAP_W'(TAPS - 1));
    assign w_fill_done = w_in_fire && (r_fill_cnt == CNT_W'(TAPS - 1));
    assign w_acc_step  = r_acc + {1'b0, step};
    assign w_acc_sub   = r_acc - FILT_L;
    assign w_load_done = w_in_fire && (w_acc_sub < FILT_L);

    // Phase is only meaningful in MAC; clamp elsewhere so the row select stays in range.
    assign w_phase    = (r_acc < FILT_L) ? r_acc[PH_W-1:0] : '0;
    assign w_didx     = TAP_W'(TAPS - 1) - r_tap;
    assign w_coef     = coef[w_phase][r_tap];
    assign w_sample   = r_d[w_didx];
    assign w_prod     = PROD_W'(w_coef) * PROD_W'(w_sample);
    assign w_sum_base = (r_tap == '0) ? SAT_MIN ^ SAT_MIN : r_sum;
    assign w_sum      = w_sum_base + ACC_W'(w_prod);
    assign w_round    = w_sum + ROUND_C;
    assign w_shift    = w_round >>> (COEF_W - 1);

    always_comb begin
        w_y = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_y = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_y = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_FILL: if (w_fill_done) w_state_n = S_MAC;
            S_MAC:  if (w_last_tap) w_state_n = S_OUT;
            S_OUT: begin
                if (w_out_fire) begin
                    w_state_n = (w_acc_step >= FILT_L) ? S_LOAD : S_MAC;
                end
            end
            S_LOAD: if (w_load_done) w_state_n = S_MAC;
            default: w_state_n = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_acc       <= '0;
            r_fill_cnt  <= '0;
            r_tap       <= '0;
            r_sum       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int k = 0; k < TAPS; k++) r_d[k] <= '0;
        end else begin
            r_state     <= w_state_n;
            r_in_ready  <= (w_state_n == S_FILL) || (w_state_n == S_LOAD);
            r_out_valid <= (w_state_n == S_OUT);
            if (w_in_fire) begin
                r_d[0] <= in_data;
                for (int k = 1; k < TAPS; k++) r_d[k] <= r_d[k-1];
            end
            case (r_state)
                S_FILL: begin
                    if (w_in_fire) r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (w_fill_done) r_acc <= '0;
                end
                S_MAC: begin
                    r_sum <= w_sum;
                    r_tap <= w_last_tap ? '0 : r_tap + 1'b1;
                    if (w_last_tap) r_out_data <= w_y;
                end
                S_OUT:  if (w_out_fire) r_acc <= w_acc_step;
                S_LOAD: if (w_in_fire) r_acc <= w_acc_sub;
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

endmodule
